// File: rtl/hamming_pkg.sv
// Shared types and elaboration-time helpers for the SECDED (extended Hamming) decoder.
package hamming_pkg;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_SINGLE,
    ERR_PARITY,
    ERR_DOUBLE
  } err_kind_e;

  // Smallest R with 2^R >= data_w + R + 1.
  function automatic int calc_r(input int data_w);
    int r;
    r = 1;
    while ((1 << r) < data_w + r + 1) r++;
    return r;
  endfunction

  // Codeword index of data bit j: the j-th non-power-of-two Hamming position, minus one.
  function automatic int data_pos(input int j);
    int pos;
    int cnt;
    pos = 2;
    cnt = -1;
    while (cnt < j) begin
      pos++;
      if ((pos & (pos - 1)) != 0) cnt++;
    end
    return pos - 1;
  endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational syndrome and overall-parity generator for an N-bit extended Hamming codeword.
module hamming_syndrome #(
  parameter int N = 8,
  parameter int R = 3
) (
  input  logic [N-1:0] code_i,
  output logic [R-1:0] syn_o,
  output logic         par_o
);

  // NOTE: every combinational output gets a default before the loops so no latch is inferred.
  always_comb begin
    syn_o = '0;
    for (int i = 0; i < N - 1; i++) begin
      for (int k = 0; k < R; k++) begin
        if ((((i + 1) >> k) & 1) != 0) syn_o[k] = syn_o[k] ^ code_i[i];
      end
    end
  end

  assign par_o = ^code_i;

endmodule

// File: rtl/hamming_secded_dec.sv
// Two-stage SECDED decoder with valid/ready on both sides and saturating error counters.
module hamming_secded_dec
  import hamming_pkg::*;
#(
  parameter  int DATA_W = 4,
  parameter  int CNT_W  = 8,
  localparam int R      = calc_r(DATA_W),
  localparam int N      = DATA_W + R + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N-1:0]      in_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [R-1:0]      out_syndrome,
  output logic              out_err_single,
  output logic              out_err_double,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  cnt_single,
  output logic [CNT_W-1:0]  cnt_double
);

  logic              s1_valid_q;
  logic [N-1:0]      s1_code_q;
  logic [R-1:0]      s1_syn_q;
  logic              s1_par_q;
  logic              s2_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic [R-1:0]      out_syn_q;
  logic              err_single_q;
  logic              err_double_q;
  logic [CNT_W-1:0]  cnt_single_q, cnt_single_d;
  logic [CNT_W-1:0]  cnt_double_q, cnt_double_d;

  logic [R-1:0]      syn_w;
  logic              par_w;
  logic              s1_adv;
  logic              in_fire;
  logic              out_fire;
  err_kind_e         kind_d;
  logic [N-1:0]      fixed_d;
  logic [DATA_W-1:0] data_d;

  hamming_syndrome #(.N(N), .R(R)) u_syndrome (
    .code_i (in_code),
    .syn_o  (syn_w),
    .par_o  (par_w)
  );

  // S1 may move on whenever S2 is empty or being drained this cycle.
  assign s1_adv   = !s2_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s1_adv;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = s2_valid_q && out_ready;

  // NOTE: sequential state uses non-blocking assignments; reset is synchronous, sampled on clk.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_code_q  <= '0;
      s1_syn_q   <= '0;
      s1_par_q   <= 1'b0;
    end else begin
      if (in_ready) s1_valid_q <= in_valid;
      if (in_fire) begin
        s1_code_q <= in_code;
        s1_syn_q  <= syn_w;
        s1_par_q  <= par_w;
      end
    end
  end

  always_comb begin
    kind_d  = ERR_NONE;
    fixed_d = s1_code_q;
    if (s1_par_q) begin
      if (s1_syn_q == '0)                kind_d = ERR_PARITY;
      else if (int'(s1_syn_q) <= N - 1)  kind_d = ERR_SINGLE;
      else                               kind_d = ERR_DOUBLE;
    end else if (s1_syn_q != '0) begin
      kind_d = ERR_DOUBLE;
    end
    if (kind_d == ERR_SINGLE) begin
      for (int i = 0; i < N - 1; i++) begin
        if (s1_syn_q == R'(i + 1)) fixed_d[i] = ~fixed_d[i];
      end
    end
    for (int j = 0; j < DATA_W; j++) data_d[j] = fixed_d[data_pos(j)];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid_q   <= 1'b0;
      out_data_q   <= '0;
      out_syn_q    <= '0;
      err_single_q <= 1'b0;
      err_double_q <= 1'b0;
    end else if (s1_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_data_q   <= data_d;
        out_syn_q    <= s1_syn_q;
        err_single_q <= (kind_d == ERR_SINGLE) || (kind_d == ERR_PARITY);
        err_double_q <= (kind_d == ERR_DOUBLE);
      end
    end
  end

  // Clear has priority over a coincident increment; both counters stick at all-ones.
  always_comb begin
    cnt_single_d = cnt_single_q;
    cnt_double_d = cnt_double_q;
    if (cnt_clr) begin
      cnt_single_d = '0;
      cnt_double_d = '0;
    end else if (out_fire) begin
      if (err_single_q && (cnt_single_q != '1)) cnt_single_d = cnt_single_q + CNT_W'(1);
      if (err_double_q && (cnt_double_q != '1)) cnt_double_d = cnt_double_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_single_q <= '0;
      cnt_double_q <= '0;
    end else begin
      cnt_single_q <= cnt_single_d;
      cnt_double_q <= cnt_double_d;
    end
  end

  assign out_valid      = s2_valid_q;
  assign out_data       = out_data_q;
  assign out_syndrome   = out_syn_q;
  assign out_err_single = err_single_q;
  assign out_err_double = err_double_q;
  assign cnt_single     = cnt_single_q;
  assign cnt_double     = cnt_double_q;

endmodule

// File: tb/tb_hamming_secded_dec.sv
// Randomized self-checking bench for hamming_secded_dec (DATA_W=4, CNT_W=2) with a positional reference model.
module tb_hamming_secded_dec;

  localparam int DW   = 4;
  localparam int CW   = 2;
  localparam int R    = 3;
  localparam int N    = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [N-1:0]  in_code = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic [R-1:0]  out_syndrome;
  logic          out_err_single;
  logic          out_err_double;
  logic          cnt_clr = 1'b0;
  logic [CW-1:0] cnt_single;
  logic [CW-1:0] cnt_double;

  hamming_secded_dec #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_code        (in_code),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_syndrome   (out_syndrome),
    .out_err_single (out_err_single),
    .out_err_double (out_err_double),
    .cnt_clr        (cnt_clr),
    .cnt_single     (cnt_single),
    .cnt_double     (cnt_double)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic [R-1:0]  syn;
    logic          es;
    logic          ed;
    int            acc_cyc;
    bit            clean;
  } exp_t;

  exp_t         sb[$];
  logic [N-1:0] tx_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int n_out = 0;
  int n_acc = 0;
  int m_cs = 0;
  int m_cd = 0;
  logic [DW-1:0] last_data;
  logic [R-1:0]  last_syn;
  logic          last_es, last_ed;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Syndrome = XOR of the positions of all set bits; data read from non-power-of-two positions.
  function automatic exp_t ref_decode(input logic [N-1:0] c);
    exp_t e;
    logic [N-1:0] w;
    int s, g, dj;
    s = 0; g = 0; dj = 0; w = c;
    for (int p = 1; p < N; p++) if (c[p-1]) s = s ^ p;
    for (int i = 0; i < N; i++) g = g ^ int'(c[i]);
    e.es = 1'b0;
    e.ed = 1'b0;
    if (g == 1 && s == 0) e.es = 1'b1;
    else if (g == 1 && s <= N - 1) begin
      e.es = 1'b1;
      w[s-1] = ~w[s-1];
    end else if (s != 0) e.ed = 1'b1;
    e.data = '0;
    for (int p = 1; p < N; p++) begin
      if ((p & (p - 1)) != 0) begin
        e.data[dj] = w[p-1];
        dj++;
      end
    end
    e.syn = s[R-1:0];
    e.acc_cyc = 0;
    e.clean = 1'b1;
    return e;
  endfunction

  function automatic logic [N-1:0] encode(input logic [DW-1:0] d);
    logic [N-1:0] c;
    logic par;
    int dj;
    c = '0; dj = 0;
    for (int p = 1; p < N; p++) begin
      if ((p & (p - 1)) != 0) begin
        c[p-1] = d[dj];
        dj++;
      end
    end
    for (int k = 0; k < R; k++) begin
      par = 1'b0;
      for (int p = 1; p < N; p++) if (((p >> k) & 1) != 0 && p != (1 << k)) par = par ^ c[p-1];
      c[(1 << k) - 1] = par;
    end
    c[N-1] = ^c[N-2:0];
    return c;
  endfunction

  function automatic logic [N-1:0] make_word(input int nerr);
    logic [N-1:0] c;
    int a, b;
    c = encode(DW'($urandom));
    a = $urandom_range(0, N - 1);
    b = (a + $urandom_range(1, N - 1)) % N;
    if (nerr >= 1) c[a] = ~c[a];
    if (nerr >= 2) c[b] = ~c[b];
    return c;
  endfunction

  // Driver: present the head of tx_q and hold it until accepted.
  initial begin
    bit fire;
    forever begin
      @(negedge clk);
      fire = in_valid && in_ready && rst_n;
      @(posedge clk);
      #1;
      if (fire) void'(tx_q.pop_front());
      if (tx_q.size() > 0) begin
        in_valid = 1'b1;
        in_code  = tx_q[0];
      end else begin
        in_valid = 1'b0;
      end
    end
  end

  // Monitor: observes stable values at the falling edge, i.e. what the next rising edge will act on.
  logic        held = 1'b0;
  logic [9:0]  held_vec;
  always @(negedge clk) begin
    exp_t e, a;
    bit   xfer;
    cyc++;
    if (!rst_n) begin
      sb.delete();
      m_cs = 0;
      m_cd = 0;
      held = 1'b0;
    end else begin
      check("cnt_single", 32'(cnt_single), m_cs);
      check("cnt_double", 32'(cnt_double), m_cd);
      check("spurious_valid", 32'(out_valid && sb.size() == 0), 0);
      if (held) check("hold", 32'({out_valid, out_data, out_syndrome, out_err_single, out_err_double}), 32'(held_vec));
      held = out_valid && !out_ready;
      held_vec = {out_valid, out_data, out_syndrome, out_err_single, out_err_double};
      if (!out_ready) foreach (sb[i]) sb[i].clean = 1'b0;
      xfer = out_valid && out_ready && sb.size() > 0;
      if (xfer) begin
        e = sb.pop_front();
        check("data", 32'(out_data), 32'(e.data));
        check("syndrome", 32'(out_syndrome), 32'(e.syn));
        check("err_single", 32'(out_err_single), 32'(e.es));
        check("err_double", 32'(out_err_double), 32'(e.ed));
        if (e.clean) check("latency", cyc - e.acc_cyc, 2);
        last_data = out_data;
        last_syn  = out_syndrome;
        last_es   = out_err_single;
        last_ed   = out_err_double;
        n_out++;
      end
      if (cnt_clr) begin
        m_cs = 0;
        m_cd = 0;
      end else if (xfer) begin
        if (e.es && m_cs < CMAX) m_cs++;
        if (e.ed && m_cd < CMAX) m_cd++;
      end
      if (in_valid && in_ready) begin
        a = ref_decode(in_code);
        a.acc_cyc = cyc;
        sb.push_back(a);
        n_acc++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((tx_q.size() > 0 || sb.size() > 0 || in_valid) && k < 300) begin
      step();
      k++;
    end
    check("drain_timeout", 32'(k < 300), 1);
  endtask

  task automatic run_dir(input string tag, input logic [N-1:0] code, input logic [DW-1:0] d,
                         input logic [R-1:0] s, input logic es, input logic ed);
    int n0;
    n0 = n_out;
    tx_q.push_back(code);
    drain();
    check({tag, "_count"}, n_out - n0, 1);
    check({tag, "_data"}, 32'(last_data), 32'(d));
    check({tag, "_syn"}, 32'(last_syn), 32'(s));
    check({tag, "_single"}, 32'(last_es), 32'(es));
    check({tag, "_double"}, 32'(last_ed), 32'(ed));
  endtask

  initial begin
    int base, k;
    logic [DW-1:0] snap;

    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_out_flags", 32'({out_syndrome, out_err_single, out_err_double}), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    step();

    run_dir("clean55", 8'h55, 4'b1011, 3'b000, 1'b0, 1'b0);
    run_dir("single45", 8'h45, 4'b1011, 3'b101, 1'b1, 1'b0);
    check("cnt_single_after_45", 32'(cnt_single), 1);
    run_dir("double50", 8'h50, 4'b1010, 3'b010, 1'b0, 1'b1);
    check("cnt_double_after_50", 32'(cnt_double), 1);
    run_dir("g0_D5", 8'hD5, 4'b1011, 3'b000, 1'b1, 1'b0);
    check("cnt_single_after_D5", 32'(cnt_single), 2);

    // Backpressure: three back-to-back words against a stalled consumer.
    out_ready = 1'b0;
    base = n_acc;
    for (int i = 0; i < 3; i++) tx_q.push_back(make_word(i));
    repeat (4) step();
    check("bp_accepted", n_acc - base, 2);
    check("bp_in_ready", 32'(in_ready), 0);
    check("bp_out_valid", 32'(out_valid), 1);
    snap = out_data;
    repeat (4) step();
    check("bp_hold_valid", 32'(out_valid), 1);
    check("bp_hold_data", 32'(out_data), 32'(snap));
    out_ready = 1'b1;
    base = n_out;
    for (int i = 1; i <= 3; i++) begin
      step();
      check("bp_release_rate", n_out - base, i);
    end
    drain();

    // Counter saturation, then clear racing an increment.
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    for (int i = 0; i < 5; i++) tx_q.push_back(make_word(1));
    drain();
    check("cnt_single_sat", 32'(cnt_single), CMAX);
    out_ready = 1'b0;
    tx_q.push_back(make_word(1));
    k = 0;
    while (!out_valid && k < 50) begin
      step();
      k++;
    end
    check("clr_wait_timeout", 32'(out_valid), 1);
    cnt_clr   = 1'b1;
    out_ready = 1'b1;
    base = n_out;
    step();
    cnt_clr = 1'b0;
    check("clr_beats_inc", 32'(cnt_single), 0);
    check("clr_word_out", n_out - base, 1);

    // Randomized traffic with consumer stalls and occasional clears.
    for (int i = 0; i < 400; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      cnt_clr   = ($urandom_range(0, 40) == 0);
      if (tx_q.size() < 2 && $urandom_range(0, 3) != 0) tx_q.push_back(make_word($urandom_range(0, 2)));
      step();
    end
    out_ready = 1'b1;
    cnt_clr   = 1'b0;
    drain();

    // Reset with words in flight.
    for (int i = 0; i < 3; i++) tx_q.push_back(make_word($urandom_range(0, 2)));
    repeat (3) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("rst_mid_out_valid", 32'(out_valid), 0);
    check("rst_mid_in_ready", 32'(in_ready), 1);
    check("rst_mid_cnt", 32'({cnt_single, cnt_double}), 0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
